// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline <-> hazard controller signal bundle      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface hazard_ctrl_if;
   logic       stall_IC;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_syscall;
   logic       id_is_llsc;
   logic       ex_memread;
   logic       ex_regwrite;
   logic [4:0] ex_wreg;
   logic       flush_done;
   logic       want_freeze;
   logic       id_bubble;
   logic       flush_req;
   logic       SYS;
   logic       flush_err;
   logic [2:0] state_dbg;

   modport master (
      output stall_IC, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_syscall, id_is_llsc, ex_memread, ex_regwrite, ex_wreg,
             flush_done,
      input  want_freeze, id_bubble, flush_req, SYS, flush_err, state_dbg
   );

   modport slave (
      input  stall_IC, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_syscall, id_is_llsc, ex_memread, ex_regwrite, ex_wreg,
             flush_done,
      output want_freeze, id_bubble, flush_req, SYS, flush_err, state_dbg
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl : load-use stall and syscall/LL/SC drain-flush control |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int DRAIN_CYCLES  = 3,
   parameter int FLUSH_TIMEOUT = 255
) (
   input  wire logic     CLK,
   input  wire logic     RESET,
   hazard_ctrl_if.slave  hz
);

   localparam int c_DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam int c_TO_W    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

   localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_ZERO = '0;
   localparam logic [c_TO_W-1:0]    c_TO_ONE     = c_TO_W'(1);
   localparam logic [c_TO_W-1:0]    c_TO_MAX     = c_TO_W'(FLUSH_TIMEOUT);
   localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(FLUSH_TIMEOUT - 1);
   localparam logic                 c_DRAIN_DIRECT = (DRAIN_CYCLES <= 1);

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_LDUSE   = 3'd1,
      S_DRAIN   = 3'd2,
      S_FLUSH   = 3'd3,
      S_SIGNAL  = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [c_DRAIN_W-1:0]   r_drain_cnt;
   logic [c_TO_W-1:0]      r_to_cnt;
   logic                   r_flush_req;
   logic                   r_sys;
   logic                   r_flush_err;
   logic                   r_llsc;

   logic                   w_enable;
   logic                   w_hazard;
   logic                   w_want_freeze;
   logic                   w_id_bubble;
   logic                   w_drain_load;
   logic                   w_enter_flush;
   logic                   w_leave_flush;
   logic                   w_timeout;
   logic                   w_latch_llsc;

   assign w_enable = ~hz.stall_IC;

   // $0 is never a real producer, so a load into it cannot create a hazard
   assign w_hazard = hz.id_valid & hz.ex_memread & hz.ex_regwrite &
                     (hz.ex_wreg != 5'd0) &
                     ((hz.id_uses_rs & (hz.id_rs == hz.ex_wreg)) |
                      (hz.id_uses_rt & (hz.id_rt == hz.ex_wreg)));

   always_comb begin
      w_next_state  = r_state;
      w_want_freeze = 1'b0;
      w_id_bubble   = 1'b0;
      w_drain_load  = 1'b0;
      w_enter_flush = 1'b0;
      w_leave_flush = 1'b0;
      w_timeout     = 1'b0;
      w_latch_llsc  = 1'b0;

      case (r_state)
         S_RUN: begin
            if (w_hazard) begin
               w_want_freeze = 1'b1;
               w_id_bubble   = 1'b1;
               w_next_state  = S_LDUSE;
            end else if (hz.id_valid && hz.id_syscall) begin
               w_want_freeze = 1'b1;
               w_id_bubble   = 1'b1;
               w_latch_llsc  = 1'b1;
               if (c_DRAIN_DIRECT) begin
                  w_enter_flush = 1'b1;
                  w_next_state  = S_FLUSH;
               end else begin
                  w_drain_load  = 1'b1;
                  w_next_state  = S_DRAIN;
               end
            end
         end

         S_LDUSE: begin
            w_next_state = S_RUN;
         end

         S_DRAIN: begin
            w_want_freeze = 1'b1;
            w_id_bubble   = 1'b1;
            // Counter reaches zero on this edge: the RUN cycle was bubble #1
            if (r_drain_cnt <= c_DRAIN_ONE) begin
               w_enter_flush = 1'b1;
               w_next_state  = S_FLUSH;
            end
         end

         S_FLUSH: begin
            w_want_freeze = 1'b1;
            w_id_bubble   = 1'b1;
            if (hz.flush_done) begin
               w_leave_flush = 1'b1;
               w_next_state  = S_SIGNAL;
            end else if (r_to_cnt == c_TO_LAST) begin
               w_leave_flush = 1'b1;
               w_timeout     = 1'b1;
               w_next_state  = S_SIGNAL;
            end
         end

         S_SIGNAL: begin
            w_want_freeze = 1'b1;
            w_next_state  = S_RELEASE;
         end

         S_RELEASE: begin
            w_next_state = S_RUN;
         end

         default: begin
            w_next_state = S_RUN;
         end
      endcase

      if (!RESET) begin
         w_want_freeze = 1'b0;
         w_id_bubble   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= S_RUN;
         r_drain_cnt <= '0;
         r_to_cnt    <= '0;
         r_flush_req <= 1'b0;
         r_sys       <= 1'b0;
         r_flush_err <= 1'b0;
         r_llsc      <= 1'b0;
      end else begin
         // SYS is a strobe: a stalled edge drops it and SIGNAL re-issues it later
         r_sys <= 1'b0;
         if (w_enable) begin
            r_state <= w_next_state;

            if (w_drain_load) begin
               r_drain_cnt <= c_DRAIN_LOAD;
            end else if ((r_state == S_DRAIN) && (r_drain_cnt != c_DRAIN_ZERO)) begin
               r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
            end

            if (w_enter_flush) begin
               r_flush_req <= 1'b1;
               r_to_cnt    <= '0;
            end else if (r_state == S_FLUSH) begin
               if (r_to_cnt != c_TO_MAX) begin
                  r_to_cnt <= r_to_cnt + c_TO_ONE;
               end
               if (w_leave_flush) begin
                  r_flush_req <= 1'b0;
               end
            end

            if (w_timeout) begin
               r_flush_err <= 1'b1;
            end

            if (w_latch_llsc) begin
               r_llsc <= hz.id_is_llsc;
            end

            if ((r_state == S_SIGNAL) && !r_llsc) begin
               r_sys <= 1'b1;
            end
         end
      end
   end

   assign hz.want_freeze = w_want_freeze;
   assign hz.id_bubble   = w_id_bubble;
   assign hz.flush_req   = r_flush_req;
   assign hz.SYS         = r_sys;
   assign hz.flush_err   = r_flush_err;
   assign hz.state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_ctrl : directed scoreboard bench for hazard_ctrl         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_hazard_ctrl;

   localparam logic [2:0] c_RUN     = 3'd0;
   localparam logic [2:0] c_LDUSE   = 3'd1;
   localparam logic [2:0] c_DRAIN   = 3'd2;
   localparam logic [2:0] c_FLUSH   = 3'd3;
   localparam logic [2:0] c_SIGNAL  = 3'd4;
   localparam logic [2:0] c_RELEASE = 3'd5;

   logic CLK;
   logic RESET;
   int   n_checks;
   int   n_errors;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   hazard_ctrl_if hif ();

   hazard_ctrl #(
      .DRAIN_CYCLES  (3),
      .FLUSH_TIMEOUT (8)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .hz    (hif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic nxt();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      hif.stall_IC    = 1'b0;
      hif.id_valid    = 1'b0;
      hif.id_rs       = 5'd0;
      hif.id_rt       = 5'd0;
      hif.id_uses_rs  = 1'b0;
      hif.id_uses_rt  = 1'b0;
      hif.id_syscall  = 1'b0;
      hif.id_is_llsc  = 1'b0;
      hif.ex_memread  = 1'b0;
      hif.ex_regwrite = 1'b0;
      hif.ex_wreg     = 5'd0;
      hif.flush_done  = 1'b0;
   endtask

   task automatic syscall_in(input logic llsc);
      hif.id_valid   = 1'b1;
      hif.id_syscall = 1'b1;
      hif.id_is_llsc = llsc;
   endtask

   task automatic load_ex(input logic [4:0] wreg);
      hif.ex_memread  = 1'b1;
      hif.ex_regwrite = 1'b1;
      hif.ex_wreg     = wreg;
   endtask

   // Push the expected observation, let inputs settle, then drain the scoreboard
   task automatic cyc(input string tag, input logic [2:0] st, input logic wf,
                      input logic bb, input logic fr, input logic sy, input logic er);
      exp_q.push_back({st, wf, bb, fr, sy, er});
      tag_q.push_back(tag);
      #2;
      while (exp_q.size() != 0) begin
         logic [7:0] exp_v;
         logic [7:0] obs_v;
         string      t;
         exp_v = exp_q.pop_front();
         t     = tag_q.pop_front();
         obs_v = {hif.state_dbg, hif.want_freeze, hif.id_bubble,
                  hif.flush_req, hif.SYS, hif.flush_err};
         n_checks++;
         assert (obs_v === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed st/wf/bb/fr/sys/err=%b required %b", t, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_inputs();
      RESET = 1'b0;

      // Reset gates the combinational outputs even with a live hazard/syscall
      nxt(); syscall_in(1'b0); load_ex(5'd5); hif.id_uses_rs = 1'b1; hif.id_rs = 5'd5;
      cyc("reset_gated", c_RUN, 0, 0, 0, 0, 0);
      nxt(); cyc("reset_hold", c_RUN, 0, 0, 0, 0, 0);
      nxt(); clear_inputs(); RESET = 1'b1;
      cyc("post_reset", c_RUN, 0, 0, 0, 0, 0);

      // Load-use on rs; hazard left asserted through LDUSE
      nxt(); hif.id_valid = 1'b1; load_ex(5'd5); hif.id_uses_rs = 1'b1; hif.id_rs = 5'd5;
      cyc("lu_rs", c_RUN, 1, 1, 0, 0, 0);
      nxt(); cyc("lu_rs_ldu", c_LDUSE, 0, 0, 0, 0, 0);
      nxt(); clear_inputs(); cyc("lu_rs_run", c_RUN, 0, 0, 0, 0, 0);

      // Load-use on rt
      nxt(); hif.id_valid = 1'b1; load_ex(5'd7); hif.id_uses_rt = 1'b1; hif.id_rt = 5'd7;
      hif.id_rs = 5'd5;
      cyc("lu_rt", c_RUN, 1, 1, 0, 0, 0);
      nxt(); clear_inputs(); cyc("lu_rt_ldu", c_LDUSE, 0, 0, 0, 0, 0);

      // Non-hazard patterns
      nxt(); hif.id_valid = 1'b1; load_ex(5'd0); hif.id_uses_rs = 1'b1; hif.id_rs = 5'd0;
      cyc("wreg_zero", c_RUN, 0, 0, 0, 0, 0);
      nxt(); load_ex(5'd9); hif.id_rs = 5'd9; hif.id_uses_rs = 1'b0;
      hif.id_uses_rt = 1'b1; hif.id_rt = 5'd3;
      cyc("no_use", c_RUN, 0, 0, 0, 0, 0);
      nxt(); hif.id_uses_rs = 1'b1; hif.ex_memread = 1'b0;
      cyc("not_load", c_RUN, 0, 0, 0, 0, 0);
      nxt(); hif.ex_memread = 1'b1; hif.id_valid = 1'b0;
      cyc("not_valid", c_RUN, 0, 0, 0, 0, 0);

      // Hazard and syscall together: hazard first, syscall follows after LDUSE
      nxt(); clear_inputs(); syscall_in(1'b0); load_ex(5'd4);
      hif.id_uses_rt = 1'b1; hif.id_rt = 5'd4;
      cyc("both_haz", c_RUN, 1, 1, 0, 0, 0);
      nxt(); hif.ex_memread = 1'b0; hif.ex_regwrite = 1'b0; hif.ex_wreg = 5'd0;
      cyc("both_ldu", c_LDUSE, 0, 0, 0, 0, 0);
      nxt(); cyc("sc_run", c_RUN, 1, 1, 0, 0, 0);
      nxt(); hif.flush_done = 1'b1;
      cyc("sc_drain1", c_DRAIN, 1, 1, 0, 0, 0);
      nxt(); hif.flush_done = 1'b0;
      cyc("sc_drain2", c_DRAIN, 1, 1, 0, 0, 0);
      nxt(); cyc("sc_flush1", c_FLUSH, 1, 1, 1, 0, 0);
      nxt(); cyc("sc_flush2", c_FLUSH, 1, 1, 1, 0, 0);
      nxt(); cyc("sc_flush3", c_FLUSH, 1, 1, 1, 0, 0);
      nxt(); hif.flush_done = 1'b1;
      cyc("sc_flush4", c_FLUSH, 1, 1, 1, 0, 0);
      nxt(); hif.flush_done = 1'b0;
      cyc("sc_signal", c_SIGNAL, 1, 0, 0, 0, 0);
      nxt(); cyc("sc_release", c_RELEASE, 0, 0, 0, 1, 0);
      nxt(); clear_inputs(); hif.flush_done = 1'b1;
      cyc("sc_run_after", c_RUN, 0, 0, 0, 0, 0);

      // LL: llsc latched on DRAIN entry, input dropped afterwards; no SYS
      nxt(); clear_inputs(); syscall_in(1'b1);
      cyc("ll_run", c_RUN, 1, 1, 0, 0, 0);
      nxt(); hif.id_is_llsc = 1'b0;
      cyc("ll_drain1", c_DRAIN, 1, 1, 0, 0, 0);
      nxt(); cyc("ll_drain2", c_DRAIN, 1, 1, 0, 0, 0);
      nxt(); cyc("ll_flush1", c_FLUSH, 1, 1, 1, 0, 0);
      nxt(); hif.flush_done = 1'b1;
      cyc("ll_flush2", c_FLUSH, 1, 1, 1, 0, 0);
      nxt(); hif.flush_done = 1'b0;
      cyc("ll_signal", c_SIGNAL, 1, 0, 0, 0, 0);
      nxt(); cyc("ll_release", c_RELEASE, 0, 0, 0, 0, 0);
      nxt(); clear_inputs(); cyc("ll_run_after", c_RUN, 0, 0, 0, 0, 0);

      // Flush timeout after 8 FLUSH cycles; flush_err is sticky
      nxt(); syscall_in(1'b0);
      cyc("to_run", c_RUN, 1, 1, 0, 0, 0);
      nxt(); cyc("to_drain1", c_DRAIN, 1, 1, 0, 0, 0);
      nxt(); cyc("to_drain2", c_DRAIN, 1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         nxt(); cyc("to_flush", c_FLUSH, 1, 1, 1, 0, 0);
      end
      nxt(); cyc("to_signal", c_SIGNAL, 1, 0, 0, 0, 1);
      nxt(); cyc("to_release", c_RELEASE, 0, 0, 0, 1, 1);
      nxt(); clear_inputs(); cyc("to_run_after", c_RUN, 0, 0, 0, 0, 1);

      // Instruction-cache stall during DRAIN and during SIGNAL
      nxt(); syscall_in(1'b0);
      cyc("st_run", c_RUN, 1, 1, 0, 0, 1);
      nxt(); hif.stall_IC = 1'b1;
      cyc("st_drain_hold", c_DRAIN, 1, 1, 0, 0, 1);
      for (int i = 1; i < 5; i++) begin
         nxt(); cyc("st_drain_hold", c_DRAIN, 1, 1, 0, 0, 1);
      end
      nxt(); hif.stall_IC = 1'b0;
      cyc("st_drain_a", c_DRAIN, 1, 1, 0, 0, 1);
      nxt(); cyc("st_drain_b", c_DRAIN, 1, 1, 0, 0, 1);
      nxt(); hif.flush_done = 1'b1;
      cyc("st_flush", c_FLUSH, 1, 1, 1, 0, 1);
      nxt(); hif.flush_done = 1'b0; hif.stall_IC = 1'b1;
      cyc("st_signal_hold", c_SIGNAL, 1, 0, 0, 0, 1);
      for (int i = 1; i < 5; i++) begin
         nxt(); cyc("st_signal_hold", c_SIGNAL, 1, 0, 0, 0, 1);
      end
      nxt(); hif.stall_IC = 1'b0;
      cyc("st_signal", c_SIGNAL, 1, 0, 0, 0, 1);
      nxt(); cyc("st_release", c_RELEASE, 0, 0, 0, 1, 1);
      nxt(); clear_inputs(); cyc("st_run_after", c_RUN, 0, 0, 0, 0, 1);

      // Asynchronous reset in FLUSH abandons the sequence
      nxt(); syscall_in(1'b0);
      cyc("rs_run", c_RUN, 1, 1, 0, 0, 1);
      nxt(); cyc("rs_drain1", c_DRAIN, 1, 1, 0, 0, 1);
      nxt(); cyc("rs_drain2", c_DRAIN, 1, 1, 0, 0, 1);
      nxt(); cyc("rs_flush", c_FLUSH, 1, 1, 1, 0, 1);
      RESET = 1'b0;
      cyc("rs_async", c_RUN, 0, 0, 0, 0, 0);
      nxt(); cyc("rs_hold", c_RUN, 0, 0, 0, 0, 0);
      nxt(); RESET = 1'b1; clear_inputs(); hif.flush_done = 1'b1;
      cyc("rs_idle", c_RUN, 0, 0, 0, 0, 0);
      nxt(); hif.flush_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nxt(); cyc("rs_idle", c_RUN, 0, 0, 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: bubble cycles inserted before a syscall/LL/SC flush request.
REQ-002 Parameter FLUSH_TIMEOUT, default 255: maximum cycles to wait for flush_done before flagging an error.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 stall_IC  input  1  instruction-cache stall; while 1, all state, counters and registered outputs hold.
REQ-006 id_valid  input  1  ID holds a real instruction this cycle.
REQ-007 id_rs, id_rt  input  5 each  ID source register numbers.
REQ-008 id_uses_rs, id_uses_rt  input  1 each  the ID instruction reads rs / rt.
REQ-009 id_syscall  input  1  ID instruction is a syscall, LL or SC (decoder Syscall flag).
REQ-010 id_is_llsc  input  1  ID instruction is LL or SC.
REQ-011 ex_memread, ex_regwrite  input  1 each  instruction in EXE is a load / writes a register.
REQ-012 ex_wreg  input  5  EXE destination register.
REQ-013 flush_done  input  1  MEM reports the cache flush is complete (single-cycle pulse).
REQ-014 want_freeze  output  1  combinational; fetch holds PC and the IF/ID register.
REQ-015 id_bubble  output  1  combinational; ID sends a NOP to EXE this cycle.
REQ-016 flush_req  output  1  registered; level request to MEM, held until flush_done.
REQ-017 SYS  output  1  registered; one-cycle pulse telling the simulator to service the syscall.
REQ-018 flush_err  output  1  registered, sticky; flush timeout occurred.
REQ-019 state_dbg  output  3  current FSM state encoding.

Function
REQ-020 FSM states: RUN=0, LDUSE=1, DRAIN=2, FLUSH=3, SIGNAL=4, RELEASE=5; encodings 6-7 return to RUN on the next enabled edge.
REQ-021 Load-use hazard = id_valid & ex_memread & ex_regwrite & ex_wreg!=0 & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
REQ-022 RUN: hazard -> want_freeze=1, id_bubble=1, next LDUSE; else id_valid & id_syscall -> want_freeze=1, id_bubble=1, load drain counter with DRAIN_CYCLES-1, next DRAIN; else both outputs 0.
REQ-023 If a hazard and a syscall occur together in RUN, the hazard wins; the syscall is re-evaluated after LDUSE.
REQ-024 LDUSE: want_freeze=0, id_bubble=0; unconditionally next RUN (exactly one bubble per load-use).
REQ-025 DRAIN: want_freeze=1, id_bubble=1; the counter decrements each enabled cycle; at 0, assert flush_req and go to FLUSH; total DRAIN_CYCLES bubbles including the RUN cycle.
REQ-026 FLUSH: want_freeze=1, id_bubble=1, flush_req=1; the timeout counter increments each enabled cycle.
REQ-027 In FLUSH, on flush_done: clear flush_req and go to SIGNAL. If the count reaches FLUSH_TIMEOUT first: set flush_err, clear flush_req and go to SIGNAL.
REQ-028 flush_done outside FLUSH is ignored.
REQ-029 SIGNAL: want_freeze=1, id_bubble=0 (the syscall instruction itself issues); SYS=1 on the next cycle only if the latched id_is_llsc was 0; next RELEASE.
REQ-030 RELEASE: want_freeze=0 (freeze inhibited), id_bubble=0, SYS cleared; next RUN. A syscall present in this cycle is not re-detected until RUN.
REQ-031 id_is_llsc is latched on entry to DRAIN and used in SIGNAL.
REQ-032 While stall_IC=1: hold the FSM and counters. want_freeze and id_bubble keep their state-derived values. SYS is forced to 0 on that edge; a pending SYS pulse is emitted after the stall ends.
REQ-033 Counter widths: the drain counter is clog2(DRAIN_CYCLES+1) bits; the timeout counter is clog2(FLUSH_TIMEOUT+1) bits and never wraps.

Reset
REQ-034 RESET low asynchronously forces: state RUN, counters 0, flush_req=0, SYS=0, flush_err=0, latched llsc=0.
REQ-035 Reset asserted mid-flush abandons the sequence with no SYS pulse; want_freeze and id_bubble are 0 while in reset.

Verification
REQ-036 Load-use: ex_memread=1, ex_regwrite=1, ex_wreg=5; ID reads rs=5 -> one cycle with want_freeze=1 and id_bubble=1, then LDUSE, then RUN. With ex_wreg=0 -> no stall.
REQ-037 Syscall with DRAIN_CYCLES=3 -> 3 bubble cycles; flush_req rises, flush_done after 4 cycles -> SIGNAL, SYS=1 for exactly one cycle, RELEASE, RUN.
REQ-038 LL with id_is_llsc=1 -> same sequence, but SYS stays 0 throughout.
REQ-039 FLUSH_TIMEOUT=8, flush_done never arrives -> flush_err=1 after 8 FLUSH cycles, SYS pulses, flush_err stays 1 until reset.
REQ-040 stall_IC held high for 5 cycles during DRAIN and again during SIGNAL -> the counter and state are frozen, and exactly one SYS pulse occurs after release.
REQ-041 RESET pulsed low while in FLUSH -> immediately state_dbg=0, flush_req=0, SYS=0, with no later SYS pulse.
